// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 pipeline-FFT stage buffer controllers.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD_A = 2'd1,
        RD_B = 2'd2
    } rd_state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

    // Butterfly partner distance of stage s in an n-point pipeline FFT.
    function automatic int stage_span(input int n, input int s);
        return n >> (s + 1);
    endfunction

endpackage

// File: rtl/fft_stage_mem_ctrl_if.sv
// Sample-in / RAM-control bundle between a stage buffer controller and its RAM.
interface fft_stage_mem_ctrl_if #(
    parameter int AW = 5
) ();
    logic          in_valid;
    logic          en_wr;
    logic [AW-1:0] wr_ptr;
    logic          en_rd;
    logic [AW-1:0] rd_ptr;
    logic [AW-2:0] tw_idx;
    logic          tw_vld;
    logic          frame_done;
    logic          ovf;

    modport master (
        input  in_valid,
        output en_wr, wr_ptr, en_rd, rd_ptr, tw_idx, tw_vld, frame_done, ovf
    );

    modport slave (
        output in_valid,
        input  en_wr, wr_ptr, en_rd, rd_ptr, tw_idx, tw_vld, frame_done, ovf
    );
endinterface

// File: rtl/fft_pair_addr_gen.sv
// Butterfly pair address and twiddle generator; walks pairs (k, k+SPAN) within groups g.
module fft_pair_addr_gen
    import fft_pkg::*;
#(
    parameter int N    = 16,
    parameter int SPAN = 8,
    parameter int AW   = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          adv,
    output logic [AW-2:0] addr_a,
    output logic [AW-2:0] addr_b,
    output logic          last,
    output logic [AW-2:0] tw_idx,
    output logic          tw_vld
);
    localparam int CW      = AW - 1;
    localparam int PW      = clog2(N) - 1;
    localparam int KS      = clog2(SPAN);
    localparam int TW_STEP = N / (2 * SPAN);

    // One pair counter; k and g are its low and high fields because SPAN is a power of two.
    logic [PW-1:0] pair_q;
    logic [CW-1:0] pair_x, k, g, tw_d, tw_q;
    logic          tw_vld_q;

    assign pair_x = CW'(pair_q);
    assign k      = pair_x & CW'(SPAN - 1);
    assign g      = pair_x >> KS;
    assign addr_a = (g << (KS + 1)) | k;
    assign addr_b = addr_a | CW'(SPAN);
    assign last   = (pair_q == '1);
    assign tw_d   = CW'(k * TW_STEP);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pair_q   <= '0;
            tw_q     <= '0;
            tw_vld_q <= 1'b0;
        end else begin
            tw_vld_q <= adv;
            if (adv) begin
                pair_q <= pair_q + 1'b1;
                tw_q   <= tw_d;
            end
        end
    end

    assign tw_idx = tw_q;
    assign tw_vld = tw_vld_q;
endmodule

// File: rtl/fft_stage_mem_ctrl.sv
// Ping-pong stage buffer controller: natural-order writes, butterfly-pair reads with aligned twiddles.
module fft_stage_mem_ctrl
    import fft_pkg::*;
#(
    parameter int N    = 16,
    parameter int SPAN = 8,
    parameter int AW   = clog2(N) + 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    fft_stage_mem_ctrl_if.master bus
);
    localparam int CW = AW - 1;

    rd_state_e     state_q, state_d;
    logic [CW-1:0] wr_cnt_q;
    logic          wr_bank_q, rd_bank_q, rd_other, ovf_q;
    logic [1:0]    bank_full_q, bank_full_d, wr_done_vec, full_nx;
    logic          wr_ok, wr_last;
    logic          rd_adv, rd_last, rd_clr, en_rd, frame_done;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] addr_a, addr_b;

    assign wr_ok    = bus.in_valid && !bank_full_q[wr_bank_q];
    assign wr_last  = wr_ok && (wr_cnt_q == CW'(N - 1));
    assign rd_other = ~rd_bank_q;

    // A bank completing this cycle counts as full for the reader's next state, so it is read next cycle.
    always_comb begin
        wr_done_vec            = '0;
        wr_done_vec[wr_bank_q] = wr_last;
        full_nx                = bank_full_q | wr_done_vec;
        bank_full_d            = full_nx;
        if (rd_clr) bank_full_d[rd_bank_q] = 1'b0;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d    = state_q;
        en_rd      = 1'b0;
        rd_ptr     = '0;
        rd_adv     = 1'b0;
        rd_clr     = 1'b0;
        frame_done = 1'b0;
        unique case (state_q)
            IDLE: if (full_nx[rd_bank_q]) state_d = RD_A;
            RD_A: begin
                en_rd   = 1'b1;
                rd_ptr  = {rd_bank_q, addr_a};
                state_d = RD_B;
            end
            RD_B: begin
                en_rd   = 1'b1;
                rd_ptr  = {rd_bank_q, addr_b};
                rd_adv  = 1'b1;
                state_d = RD_A;
                if (rd_last) begin
                    frame_done = 1'b1;
                    rd_clr     = 1'b1;
                    state_d    = full_nx[rd_other] ? RD_A : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            bank_full_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bank_full_q <= bank_full_d;
            if (wr_ok) begin
                wr_cnt_q <= wr_cnt_q + 1'b1;
                if (wr_last) wr_bank_q <= ~wr_bank_q;
            end
            if (bus.in_valid && bank_full_q[wr_bank_q]) ovf_q <= 1'b1;
            if (rd_clr) rd_bank_q <= ~rd_bank_q;
        end
    end

    fft_pair_addr_gen #(
        .N    (N),
        .SPAN (SPAN),
        .AW   (AW)
    ) u_pair_addr_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .adv    (rd_adv),
        .addr_a (addr_a),
        .addr_b (addr_b),
        .last   (rd_last),
        .tw_idx (bus.tw_idx),
        .tw_vld (bus.tw_vld)
    );

    assign bus.en_wr      = wr_ok;
    assign bus.wr_ptr     = {wr_bank_q, wr_cnt_q};
    assign bus.en_rd      = en_rd;
    assign bus.rd_ptr     = rd_ptr;
    assign bus.frame_done = frame_done;
    assign bus.ovf        = ovf_q;
endmodule
